fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, issues in-order word fetches with a
// two-credit window, buffers returned words and squashes wrong-path fetches on redirect.
module fetch_unit #(
   parameter int                   CPU_WIDTH = 32,
   parameter logic [CPU_WIDTH-1:0] RESET_PC  = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 imem_req_valid,
   input  logic                 imem_req_ready,
   output logic [CPU_WIDTH-1:0] imem_req_addr,
   input  logic                 imem_rsp_valid,
   input  logic [CPU_WIDTH-1:0] imem_rsp_data,
   input  logic                 redirect_valid,
   input  logic [CPU_WIDTH-1:0] redirect_pc,
   output logic                 inst_valid,
   input  logic                 inst_ready,
   output logic [CPU_WIDTH-1:0] inst_data,
   output logic [CPU_WIDTH-1:0] inst_pc
);

   typedef struct packed {
      logic [CPU_WIDTH-1:0] pc;
      logic                 epoch;
   } tag_t;

   typedef struct packed {
      logic [CPU_WIDTH-1:0] pc;
      logic [CPU_WIDTH-1:0] data;
   } inst_t;

   logic [CPU_WIDTH-1:0] pc;
   logic                 epoch;

   tag_t                 tag_q [2];
   logic                 tag_wr;
   logic                 tag_rd;
   logic [1:0]           in_flight;

   inst_t                fifo_q [2];
   logic                 fifo_wr;
   logic                 fifo_rd;
   logic [1:0]           fifo_count;

   logic [2:0]           occupancy;
   logic                 req_fire;
   logic                 rsp_pop;
   logic                 rsp_keep;
   logic                 inst_fire;
   logic [CPU_WIDTH-1:0] target_pc;

   // Credit uses registered counts only, so a same-cycle pop never frees a slot early.
   assign occupancy      = {1'b0, in_flight} + {1'b0, fifo_count};
   assign imem_req_valid = rst_n && !redirect_valid && (occupancy < 3'd2);
   assign imem_req_addr  = pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign rsp_pop   = imem_rsp_valid && (in_flight != 2'd0);
   assign rsp_keep  = rsp_pop && !redirect_valid && (tag_q[tag_rd].epoch == epoch);

   assign inst_valid = (fifo_count != 2'd0) && !redirect_valid;
   assign inst_data  = fifo_q[fifo_rd].data;
   assign inst_pc    = fifo_q[fifo_rd].pc;
   assign inst_fire  = inst_valid && inst_ready;

   assign target_pc = redirect_pc & ~CPU_WIDTH'(3);

   // PC, epoch and in-flight tag queue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc        <= RESET_PC;
         epoch     <= 1'b0;
         tag_wr    <= 1'b0;
         tag_rd    <= 1'b0;
         in_flight <= 2'd0;
         // NOTE: the tiny queues are reset so no X ever reaches an output mux.
         for (int i = 0; i < 2; i++) tag_q[i] <= '0;
      end else begin
         // NOTE: non-blocking throughout so every update sees pre-edge values.
         if (req_fire) begin
            tag_q[tag_wr] <= '{pc: pc, epoch: epoch};
            tag_wr        <= ~tag_wr;
            pc            <= pc + CPU_WIDTH'(4);
         end
         if (rsp_pop) tag_rd <= ~tag_rd;

         unique case ({req_fire, rsp_pop})
            2'b10:   in_flight <= in_flight + 2'd1;
            2'b01:   in_flight <= in_flight - 2'd1;
            default: ;
         endcase

         // Stamp outstanding tags with the old epoch so repeated redirects
         // can never toggle the epoch back into a match with a stale fetch.
         if (redirect_valid) begin
            pc    <= target_pc;
            epoch <= ~epoch;
            for (int i = 0; i < 2; i++) tag_q[i].epoch <= epoch;
         end
      end
   end

   // Decode-side instruction FIFO; a redirect flushes it in one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_wr    <= 1'b0;
         fifo_rd    <= 1'b0;
         fifo_count <= 2'd0;
         for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
      end else if (redirect_valid) begin
         fifo_wr    <= 1'b0;
         fifo_rd    <= 1'b0;
         fifo_count <= 2'd0;
      end else begin
         if (rsp_keep) begin
            fifo_q[fifo_wr] <= '{pc: tag_q[tag_rd].pc, data: imem_rsp_data};
            fifo_wr         <= ~fifo_wr;
         end
         if (inst_fire) fifo_rd <= ~fifo_rd;

         unique case ({rsp_keep, inst_fire})
            2'b10:   fifo_count <= fifo_count + 2'd1;
            2'b01:   fifo_count <= fifo_count - 2'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a random in-order memory and decode stage
// are checked against a program-order model built from queues.
module tb_fetch_unit;

   localparam int          W      = 32;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic          clk;
   logic          rst_n;
   logic          imem_req_valid;
   logic          imem_req_ready;
   logic [W-1:0]  imem_req_addr;
   logic          imem_rsp_valid;
   logic [W-1:0]  imem_rsp_data;
   logic          redirect_valid;
   logic [W-1:0]  redirect_pc;
   logic          inst_valid;
   logic          inst_ready;
   logic [W-1:0]  inst_data;
   logic [W-1:0]  inst_pc;

   fetch_unit #(.CPU_WIDTH(W), .RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          gen;
      int          due;
   } mem_req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } inst_t;

   // Model: requests the memory still owes, and the program-order instructions decode may take.
   mem_req_t    mem_q  [$];
   inst_t       fifo_q [$];
   logic [31:0] exp_pc;
   int          gen;
   int          cyc;

   int n_cmp;
   int n_err;

   int          p_ready, p_rsp, p_dec, p_redir, p_spur, lat_min, lat_max;
   bit          force_redir;
   logic [31:0] force_pc;

   int          n_deliv;
   logic [31:0] last_deliv_pc;
   logic [31:0] req_log [$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
   endfunction

   function automatic logic [31:0] rand_target();
      case ($urandom_range(3))
         0:       return $urandom;
         1:       return 32'hFFFF_FFF0 | 32'($urandom_range(15));
         default: return 32'($urandom_range(255));
      endcase
   endfunction

   task automatic set_knobs(input int rdy, input int rsp, input int dec, input int redir,
                            input int spur, input int lmin, input int lmax);
      p_ready = rdy; p_rsp = rsp; p_dec = dec; p_redir = redir;
      p_spur = spur; lat_min = lmin; lat_max = lmax;
   endtask

   // One clock: drive at negedge, compare before posedge, advance the model across the edge.
   task automatic step();
      bit       exp_req, exp_inst, rsp_ok;
      mem_req_t r;
      @(negedge clk);
      redirect_valid = force_redir || ($urandom_range(99) < p_redir);
      redirect_pc    = force_redir ? force_pc : rand_target();
      imem_req_ready = ($urandom_range(99) < p_ready);
      inst_ready     = ($urandom_range(99) < p_dec);
      if (mem_q.size() != 0) rsp_ok = (mem_q[0].due <= cyc) && ($urandom_range(99) < p_rsp);
      else                   rsp_ok = ($urandom_range(99) < p_spur);
      imem_rsp_valid = rsp_ok;
      imem_rsp_data  = (mem_q.size() != 0) ? mem_word(mem_q[0].addr) : $urandom;
      #2;

      exp_req = !redirect_valid && (mem_q.size() + fifo_q.size() < 2);
      n_cmp++;
      if (imem_req_valid !== exp_req) begin
         n_err++;
         $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_req);
      end
      if (exp_req) begin
         n_cmp++;
         if (imem_req_addr !== exp_pc) begin
            n_err++;
            $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, exp_pc);
         end
      end
      exp_inst = (fifo_q.size() != 0) && !redirect_valid;
      n_cmp++;
      if (inst_valid !== exp_inst) begin
         n_err++;
         $display("FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, exp_inst);
      end
      if (exp_inst) begin
         n_cmp++;
         if (inst_pc !== fifo_q[0].pc || inst_data !== fifo_q[0].data) begin
            n_err++;
            $display("FAIL inst_word cyc=%0d got=%h/%h exp=%h/%h", cyc, inst_pc, inst_data,
                     fifo_q[0].pc, fifo_q[0].data);
         end
      end

      if (imem_req_valid === 1'b1 && imem_req_ready) req_log.push_back(imem_req_addr);
      if (inst_valid === 1'b1 && inst_ready) begin
         n_deliv++;
         last_deliv_pc = inst_pc;
      end

      if (exp_inst && inst_ready) void'(fifo_q.pop_front());
      if (imem_rsp_valid && mem_q.size() != 0) begin
         r = mem_q.pop_front();
         if (!redirect_valid && r.gen == gen) fifo_q.push_back('{r.addr, mem_word(r.addr)});
      end
      if (exp_req && imem_req_ready) begin
         mem_q.push_back('{exp_pc, gen, cyc + int'($urandom_range(lat_max, lat_min))});
         exp_pc += 32'd4;
      end
      if (redirect_valid) begin
         exp_pc = redirect_pc & 32'hFFFF_FFFC;
         gen++;
         fifo_q.delete();
      end
      @(posedge clk);
      cyc++;
   endtask

   task automatic quiet_inputs();
      redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0;
   endtask

   task automatic test_reset();
      quiet_inputs();
      rst_n = 1'b0;
      #3;
      n_cmp++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst_pc !== '0 || inst_data !== '0) begin
         n_err++;
         $display("FAIL reset_outputs got req=%b iv=%b pc=%h data=%h exp all zero",
                  imem_req_valid, inst_valid, inst_pc, inst_data);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
         n_err++;
         $display("FAIL first_req got valid=%b addr=%h exp 1/%h", imem_req_valid, imem_req_addr, RST_PC);
      end
      exp_pc = RST_PC; gen = 0; mem_q.delete(); fifo_q.delete(); n_deliv = 0;
   endtask

   task automatic test_stream();
      set_knobs(100, 100, 100, 0, 0, 1, 1);
      repeat (30) step();
      n_cmp++;
      if (n_deliv < 15) begin
         n_err++;
         $display("FAIL stream_rate got=%0d deliveries exp>=15", n_deliv);
      end
      n_cmp++;
      if (last_deliv_pc !== RST_PC + 32'(4 * (n_deliv - 1))) begin
         n_err++;
         $display("FAIL stream_order got=%h exp=%h", last_deliv_pc, RST_PC + 32'(4 * (n_deliv - 1)));
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] saved;
      int          d0;
      bit          seen;
      saved = last_deliv_pc;
      set_knobs(100, 100, 0, 0, 0, 1, 1);
      repeat (10) step();
      #1;
      n_cmp++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b1) begin
         n_err++;
         $display("FAIL stall_full got req=%b iv=%b exp 0/1", imem_req_valid, inst_valid);
      end
      p_dec = 100;
      d0 = n_deliv;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step();
         seen = (n_deliv > d0);
      end
      n_cmp++;
      if (!seen || last_deliv_pc !== saved + 32'd4) begin
         n_err++;
         $display("FAIL stall_resume got seen=%b pc=%h exp pc=%h", seen, last_deliv_pc, saved + 32'd4);
      end
      repeat (20) step();
   endtask

   task automatic test_redirect_inflight();
      bit ok;
      int d0;
      set_knobs(100, 100, 100, 0, 0, 3, 3);
      req_log.delete();
      force_redir = 1'b1; force_pc = 32'h10;
      step();
      force_redir = 1'b0;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         ok = (mem_q.size() == 2) && (mem_q[0].gen == gen) && (mem_q[1].gen == gen);
         if (!ok) step();
      end
      n_cmp++;
      if (!ok || req_log.size() < 2 || req_log[0] !== 32'h10 || req_log[1] !== 32'h14) begin
         n_err++;
         $display("FAIL inflight_setup got ok=%b reqs=%0d exp two requests 10/14", ok, req_log.size());
      end
      force_redir = 1'b1; force_pc = 32'h100;
      step();
      force_redir = 1'b0;
      d0 = n_deliv;
      for (int i = 0; i < 30 && n_deliv == d0; i++) step();
      n_cmp++;
      if (n_deliv == d0 || last_deliv_pc !== 32'h100) begin
         n_err++;
         $display("FAIL inflight_redirect got pc=%h exp=00000100", last_deliv_pc);
      end
   endtask

   task automatic test_redirect_collision();
      bit ok;
      int d0;
      set_knobs(100, 100, 100, 0, 0, 1, 1);
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         ok = (mem_q.size() != 0) && (mem_q[0].due <= cyc) && (fifo_q.size() != 0);
         if (!ok) step();
      end
      n_cmp++;
      if (!ok) begin
         n_err++;
         $display("FAIL collision_setup got no rsp+inst cycle within budget exp one");
      end
      d0 = n_deliv;
      req_log.delete();
      force_redir = 1'b1; force_pc = 32'h300;
      step();
      force_redir = 1'b0;
      n_cmp++;
      if (n_deliv != d0) begin
         n_err++;
         $display("FAIL collision_handshake got=%0d deliveries exp=0", n_deliv - d0);
      end
      for (int i = 0; i < 10 && req_log.size() == 0; i++) step();
      n_cmp++;
      if (req_log.size() == 0 || req_log[0] !== 32'h300) begin
         n_err++;
         $display("FAIL collision_target got reqs=%0d exp first addr=00000300", req_log.size());
      end
      d0 = n_deliv;
      for (int i = 0; i < 20 && n_deliv == d0; i++) step();
      n_cmp++;
      if (n_deliv == d0 || last_deliv_pc !== 32'h300) begin
         n_err++;
         $display("FAIL collision_next got pc=%h exp=00000300", last_deliv_pc);
      end
   endtask

   task automatic test_align_wrap();
      set_knobs(100, 100, 100, 0, 0, 1, 2);
      req_log.delete();
      force_redir = 1'b1; force_pc = 32'h203;
      step();
      force_redir = 1'b0;
      for (int i = 0; i < 10 && req_log.size() == 0; i++) step();
      n_cmp++;
      if (req_log.size() == 0 || req_log[0] !== 32'h200) begin
         n_err++;
         $display("FAIL align got reqs=%0d exp addr=00000200", req_log.size());
      end
      req_log.delete();
      force_redir = 1'b1; force_pc = 32'hFFFF_FFFC;
      step();
      force_redir = 1'b0;
      for (int i = 0; i < 20 && req_log.size() < 2; i++) step();
      n_cmp++;
      if (req_log.size() < 2 || req_log[0] !== 32'hFFFF_FFFC || req_log[1] !== 32'h0) begin
         n_err++;
         $display("FAIL wrap got reqs=%0d exp fffffffc then 00000000", req_log.size());
      end
   endtask

   task automatic test_random();
      for (int blk = 0; blk < 15; blk++) begin
         set_knobs($urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(100, 30),
                   $urandom_range(8), $urandom_range(20), 1, $urandom_range(4, 1));
         repeat (200) step();
      end
   endtask

   task automatic test_reset_mid();
      int d0;
      set_knobs(100, 100, 100, 0, 0, 1, 1);
      repeat (15) step();
      #3;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst_pc !== '0 || inst_data !== '0) begin
         n_err++;
         $display("FAIL midreset_outputs got req=%b iv=%b pc=%h data=%h exp all zero",
                  imem_req_valid, inst_valid, inst_pc, inst_data);
      end
      quiet_inputs();
      mem_q.delete(); fifo_q.delete(); exp_pc = RST_PC; gen++;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
         n_err++;
         $display("FAIL midreset_restart got valid=%b addr=%h exp 1/%h", imem_req_valid, imem_req_addr, RST_PC);
      end
      d0 = n_deliv;
      for (int i = 0; i < 10 && n_deliv == d0; i++) step();
      n_cmp++;
      if (n_deliv == d0 || last_deliv_pc !== RST_PC) begin
         n_err++;
         $display("FAIL midreset_first got pc=%h exp=%h", last_deliv_pc, RST_PC);
      end
      repeat (20) step();
   endtask

   initial begin
      n_cmp = 0; n_err = 0; cyc = 0; gen = 0; n_deliv = 0;
      last_deliv_pc = '0; force_redir = 1'b0; force_pc = '0; exp_pc = RST_PC;
      set_knobs(100, 100, 100, 0, 0, 1, 1);
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_inflight();
      test_redirect_collision();
      test_align_wrap();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog expired");
   end

endmodule
